data_sram_responder: RTL and testbench
======================================

# data_sram_responder

Memory-side responder for the CPU's data SRAM port once it moves from the single-cycle, same-cycle-read interface to a request/acknowledge handshake. It accepts one request at a time from the CPU core (initiator), holds it for a configurable number of wait states, then commits the write or returns read data with a one-cycle `data_ok` pulse. It sits between `mycpu` data-side logic and a word-addressed on-chip array. It is also the bench memory model for CPU latency testing.

## Interface
- `ADDR_W`, 12 — log2 of array depth in 32-bit words (4096 words = 16 KiB).
- `BASE_ADDR`, 32'h1c00_0000 — byte address of word 0; must be aligned to 2^(ADDR_W+2).
- `LATENCY`, 2 — wait-state cycles between accept and response, 0..15.
- `clk` in 1 — clock, all logic on rising edge.
- `reset` in 1 — synchronous, active-high reset.
- `req` in 1 — request valid from initiator.
- `wr` in 1 — 1 = write, 0 = read; sampled with `req`.
- `wstrb` in 4 — byte write enables; bit i covers `wdata[8i+7:8i]`; ignored on reads.
- `addr` in 32 — byte address; `addr[1:0]` ignored (word access).
- `wdata` in 32 — write data.
- `addr_ok` out 1 — request accepted this cycle when `req && addr_ok`.
- `data_ok` out 1 — one-cycle response pulse; read data valid / write committed.
- `rdata` out 32 — read data, valid when `data_ok`; held until the next `data_ok`.
- `err` out 1 — asserted with `data_ok` when the accepted address was out of range.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE: `addr_ok` = 1. On accept: latch `wr`, `wstrb`, the word index `addr[ADDR_W+1:2]`, `wdata`, and `oor` (out of range). Load the counter with `LATENCY`. Go to WAIT if `LATENCY` > 0, else go to RESP.
  - WAIT: `addr_ok` = 0. Decrement the counter. When the counter equals 1, go to RESP.
  - RESP: `data_ok` = 1 and `err` = `oor`. Write: update enabled bytes at the latched index, unless `oor`. Read: `rdata` = array[index], or 0 if `oor`. `addr_ok` = 1 in RESP.
    - Accept in the same cycle: reload and go to WAIT or RESP as from IDLE.
    - No accept: go to IDLE.
- Out of range is defined as: `addr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]`. An out-of-range request has no array side effect.
- Only one request is outstanding at a time. `req` held while `addr_ok` = 0 has no effect; the initiator keeps it asserted.
- Read-after-write ordering:
  - A write commits at the RESP clock edge.
  - A request accepted during that RESP cycle reads at its own RESP.
  - That read therefore always returns the new data.
- `wstrb` = 0 on a write still completes a handshake and changes nothing.

## Timing
- Accept in cycle N → `data_ok` in cycle N+1+LATENCY.
- Peak throughput: one request per LATENCY+1 cycles, using back-to-back accept in RESP.
- Reset values: state = IDLE, `addr_ok` = 1 (the cycle after reset deasserts; 0 while `reset` is high), `data_ok` = 0, `err` = 0, `rdata` = 0, counter = 0.
- Reset mid-operation:
  - A pending request is dropped and no write is committed.
  - No `data_ok` is issued for the dropped request.
  - Array contents are preserved.
- `reset` and `req` in the same cycle: the request is not accepted.
- `rdata` is registered. There is no combinational path from `req`/`addr` to `data_ok`/`rdata`.
- `addr_ok` depends only on state (registered decode). There is no path from `req`.

## Structure
- Package `sram_resp_pkg` contains:
  - the state enum (IDLE/WAIT/RESP);
  - the counter width constant `LAT_W` = 4;
  - the bus width constants (`DATA_W` = 32, `STRB_W` = 4).
- Sub-module `sram_resp_mem`: synchronous single-port word array with byte enables.
  - Inputs: `en`, `we[3:0]`, `idx`, `din`. Output: `dout`, registered.
  - Synthesizes to BRAM.
  - The FSM drives it in RESP. The read port is issued one cycle earlier, so `dout` lands in RESP.
  - For LATENCY = 0, the read is issued at the accept edge from the incoming `addr`.
- Top `data_sram_responder` contains the FSM, latch registers, counter, and range check.

## Test plan
- Reset with `req` held high (LATENCY = 2) → `addr_ok` = 0 during reset. The first accept occurs the cycle after reset falls. `data_ok` stays 0 during reset.
- Write 0x1c00_0010, `wdata` 0xdead_beef, `wstrb` 4'b1111; then read the same address → read `data_ok` exactly 3 cycles after its accept, `rdata` 0xdead_beef, `err` 0.
- Partial write of 0x1122_3344 with `wstrb` 4'b0101 over 0xdead_beef; read back → 0xde22_be44.
- LATENCY = 0 back-to-back: write 0xa5a5_a5a5 to 0x1c00_0020, then a read of the same address accepted in the write's RESP cycle → `data_ok` on consecutive cycles, read returns 0xa5a5_a5a5.
- Read 0x1d00_0000 (out of range) → `data_ok` = 1, `err` = 1, `rdata` = 0. A following write to 0x1d00_0000 changes no array word (check 0x1c00_0000 is unchanged).
- Assert reset while in WAIT of a write to 0x1c00_0030 → no `data_ok`, and a read of 0x1c00_0030 after reset returns the prior contents.

Source files
------------

// File: rtl/sram_resp_pkg.sv
// Shared types and widths for the data SRAM responder.
// Holds the handshake FSM state encoding and the bus and counter widths.
package sram_resp_pkg;

   localparam int LAT_W  = 4;
   localparam int DATA_W = 32;
   localparam int STRB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/sram_resp_mem.sv
// Single-port word array with per-byte write enables and a registered read port.
// The read is read-first, and the coding style lets the array map onto block RAM.
module sram_resp_mem
   import sram_resp_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              en,
   input  logic [STRB_W-1:0] we,
   input  logic [ADDR_W-1:0] idx,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   logic [DATA_W-1:0] r_mem [2**ADDR_W];
   logic [DATA_W-1:0] r_dout;

   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (we[i]) begin
               r_mem[idx][8*i +: 8] <= din[8*i +: 8];
            end
         end
         r_dout <= r_mem[idx];
      end
   end

   assign dout = r_dout;

endmodule

// File: rtl/data_sram_responder.sv
// Request/acknowledge responder for the CPU data SRAM port.
// It accepts one request at a time, waits LATENCY cycles, then pulses data_ok.
module data_sram_responder
   import sram_resp_pkg::*;
#(
   parameter int          ADDR_W    = 12,
   parameter logic [31:0] BASE_ADDR = 32'h1c00_0000,
   parameter int          LATENCY   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              wr,
   input  logic [STRB_W-1:0] wstrb,
   input  logic [31:0]       addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              addr_ok,
   output logic              data_ok,
   output logic [DATA_W-1:0] rdata,
   output logic              err
);

   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LATENCY);

   state_t            r_state;
   state_t            w_nextState;
   logic [LAT_W-1:0]  r_count;
   logic              r_addrOk;
   logic              r_wr;
   logic              r_oor;
   logic [STRB_W-1:0] r_wstrb;
   logic [ADDR_W-1:0] r_idx;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;

   logic              w_accept;
   logic              w_inOor;
   logic [ADDR_W-1:0] w_inIdx;
   logic [1:0]        w_unusedAddr;
   logic [DATA_W-1:0] w_rdResp;

   logic              w_memEn;
   logic [STRB_W-1:0] w_memWe;
   logic [ADDR_W-1:0] w_memIdx;
   logic [DATA_W-1:0] w_memDin;
   logic [DATA_W-1:0] w_memDout;

   assign w_accept     = r_addrOk & req & ~reset;
   assign w_inIdx      = addr[ADDR_W+1:2];
   assign w_inOor      = addr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2];
   assign w_unusedAddr = addr[1:0];

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE, RESP: begin
            if (w_accept) begin
               w_nextState = (LATENCY == 0) ? RESP : WAIT;
            end else begin
               w_nextState = IDLE;
            end
         end
         WAIT: begin
            if (r_count == LAT_W'(1)) begin
               w_nextState = RESP;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_count  <= '0;
         r_addrOk <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_state  <= w_nextState;
         r_addrOk <= (w_nextState != WAIT);
         if (w_accept) begin
            r_count <= LAT_INIT;
         end else if (r_state == WAIT) begin
            r_count <= r_count - LAT_W'(1);
         end
         if (r_state == RESP && !r_wr) begin
            r_rdata <= w_rdResp;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_wr    <= wr;
         r_wstrb <= wstrb;
         r_idx   <= w_inIdx;
         r_wdata <= wdata;
         r_oor   <= w_inOor;
      end
   end

   // The array is touched on the edge that enters RESP, so a write and a read
   // accepted during its RESP never need the single port on the same edge.
   always_comb begin
      w_memEn  = 1'b0;
      w_memWe  = '0;
      w_memIdx = r_idx;
      w_memDin = r_wdata;
      if (LATENCY == 0) begin
         if (w_accept) begin
            w_memEn  = 1'b1;
            w_memIdx = w_inIdx;
            w_memDin = wdata;
            if (wr && !w_inOor) begin
               w_memWe = wstrb;
            end
         end
      end else if (r_state == WAIT && r_count == LAT_W'(1) && !reset) begin
         w_memEn = 1'b1;
         if (r_wr && !r_oor) begin
            w_memWe = r_wstrb;
         end
      end
   end

   sram_resp_mem #(
      .ADDR_W(ADDR_W)
   ) u_mem (
      .clk (clk),
      .en  (w_memEn),
      .we  (w_memWe),
      .idx (w_memIdx),
      .din (w_memDin),
      .dout(w_memDout)
   );

   assign w_rdResp = r_oor ? '0 : w_memDout;
   assign addr_ok  = r_addrOk;
   assign data_ok  = (r_state == RESP);
   assign err      = data_ok & r_oor;
   assign rdata    = (data_ok && !r_wr) ? w_rdResp : r_rdata;

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench: two responders (LATENCY 2 and 0) driven by directed and
// random transactions, checked against a word-array reference model.
module tb_data_sram_responder;

   localparam logic [31:0] BASE = 32'h1c00_0000;

   logic        clk = 1'b0;
   logic        reset  [2];
   logic        req    [2];
   logic        wr     [2];
   logic [3:0]  wstrb  [2];
   logic [31:0] addr   [2];
   logic [31:0] wdata  [2];
   logic        addrOk [2];
   logic        dataOk [2];
   logic [31:0] rdata  [2];
   logic        err    [2];

   int          nChecks = 0;
   int          nPass   = 0;
   int          latOf [2] = '{2, 0};
   logic [31:0] model [2][32];

   always #5 clk = ~clk;

   data_sram_responder #(.ADDR_W(12), .BASE_ADDR(BASE), .LATENCY(2)) dutLat2 (
      .clk(clk), .reset(reset[0]), .req(req[0]), .wr(wr[0]), .wstrb(wstrb[0]),
      .addr(addr[0]), .wdata(wdata[0]), .addr_ok(addrOk[0]), .data_ok(dataOk[0]),
      .rdata(rdata[0]), .err(err[0]));

   data_sram_responder #(.ADDR_W(12), .BASE_ADDR(BASE), .LATENCY(0)) dutLat0 (
      .clk(clk), .reset(reset[1]), .req(req[1]), .wr(wr[1]), .wstrb(wstrb[1]),
      .addr(addr[1]), .wdata(wdata[1]), .addr_ok(addrOk[1]), .data_ok(dataOk[1]),
      .rdata(rdata[1]), .err(err[1]));

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got === exp) nPass++;
      else $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   // Called on a falling edge; returns on the falling edge where data_ok is seen.
   task automatic applyStimulus(input int sel, input bit isWr, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] s, input string tag,
                                output int waited, output logic [31:0] rd);
      bit          inRange;
      int          idx;
      int          k;
      logic [31:0] expWord;
      inRange = (a >> 14) == (BASE >> 14);
      idx     = int'((a - BASE) >> 2);
      req[sel] = 1'b1; wr[sel] = isWr; addr[sel] = a; wdata[sel] = d; wstrb[sel] = s;
      waited = 0;
      rd     = '0;
      while (addrOk[sel] !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (addrOk[sel] !== 1'b1) begin
         checkOutput({tag, "_accept_timeout"}, 32'd0, 32'd1);
         req[sel] = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      req[sel] = 1'b0;
      k = 0;
      while (dataOk[sel] !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (dataOk[sel] !== 1'b1) begin
         checkOutput({tag, "_dataok_timeout"}, 32'd0, 32'd1);
         return;
      end
      checkOutput({tag, "_lat"}, k, latOf[sel]);
      checkOutput({tag, "_err"}, {31'd0, err[sel]}, {31'd0, !inRange});
      rd = rdata[sel];
      if (isWr) begin
         if (inRange) begin
            for (int b = 0; b < 4; b++) begin
               if (s[b]) model[sel][idx][8*b +: 8] = d[8*b +: 8];
            end
         end
      end else begin
         expWord = inRange ? model[sel][idx] : 32'd0;
         checkOutput({tag, "_rdata"}, rdata[sel], expWord);
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          waited;
      logic [31:0] rd;
      logic [31:0] word0;
      logic [31:0] a;
      for (int s = 0; s < 2; s++) begin
         reset[s] = 1'b1; req[s] = 1'b0; wr[s] = 1'b0; wstrb[s] = '0;
         addr[s] = '0; wdata[s] = '0;
      end

      // Reset held with a pending write request on the LATENCY=2 responder
      req[0] = 1'b1; wr[0] = 1'b1; addr[0] = BASE + 32'h40;
      wdata[0] = 32'h0bad_f00d; wstrb[0] = 4'hf;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("rst_addr_ok", {31'd0, addrOk[0]}, 32'd0);
         checkOutput("rst_data_ok", {31'd0, dataOk[0]}, 32'd0);
      end
      reset[0] = 1'b0;
      reset[1] = 1'b0;
      checkOutput("rst_rdata", rdata[0], 32'd0);
      checkOutput("rst_err", {31'd0, err[0]}, 32'd0);
      applyStimulus(0, 1'b1, BASE + 32'h40, 32'h0bad_f00d, 4'hf, "rstHeld", waited, rd);
      checkOutput("rst_first_accept", waited, 32'd1);
      applyStimulus(0, 1'b0, BASE + 32'h40, 32'd0, 4'h0, "rstHeldRd", waited, rd);

      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 32; i++) begin
            applyStimulus(s, 1'b1, BASE + 32'(i * 4), $urandom, 4'hf, "preload", waited, rd);
         end
      end

      // Directed cases on the LATENCY=2 responder
      applyStimulus(0, 1'b1, BASE + 32'h10, 32'hdead_beef, 4'hf, "wr10", waited, rd);
      applyStimulus(0, 1'b0, BASE + 32'h10, 32'd0, 4'h0, "rd10", waited, rd);
      checkOutput("rd10_value", rd, 32'hdead_beef);
      applyStimulus(0, 1'b1, BASE + 32'h10, 32'h1122_3344, 4'b0101, "partWr", waited, rd);
      applyStimulus(0, 1'b0, BASE + 32'h10, 32'd0, 4'h0, "partRd", waited, rd);
      checkOutput("partial_value", rd, 32'hde22_be44);

      applyStimulus(0, 1'b0, 32'h1d00_0000, 32'd0, 4'h0, "oorRd", waited, rd);
      checkOutput("oor_rdata_zero", rd, 32'd0);
      word0 = model[0][0];
      applyStimulus(0, 1'b1, 32'h1d00_0000, 32'h1234_5678, 4'hf, "oorWr", waited, rd);
      applyStimulus(0, 1'b0, BASE, 32'd0, 4'h0, "oorChk", waited, rd);
      checkOutput("oor_no_change", rd, word0);

      applyStimulus(0, 1'b1, BASE + 32'h30, 32'h5a5a_0030, 4'hf, "preRst", waited, rd);
      @(negedge clk);
      req[0] = 1'b1; wr[0] = 1'b1; addr[0] = BASE + 32'h30;
      wdata[0] = 32'hfeed_face; wstrb[0] = 4'hf;
      checkOutput("midrst_addr_ok", {31'd0, addrOk[0]}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      req[0] = 1'b0;
      reset[0] = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checkOutput("midrst_data_ok_in_reset", {31'd0, dataOk[0]}, 32'd0);
      end
      reset[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("midrst_data_ok_after", {31'd0, dataOk[0]}, 32'd0);
      end
      applyStimulus(0, 1'b0, BASE + 32'h30, 32'd0, 4'h0, "midrstRd", waited, rd);
      checkOutput("midrst_prior_value", rd, 32'h5a5a_0030);

      // Back-to-back on the LATENCY=0 responder: read accepted in the write's RESP
      applyStimulus(1, 1'b1, BASE + 32'h20, 32'ha5a5_a5a5, 4'hf, "b2bWr", waited, rd);
      applyStimulus(1, 1'b0, BASE + 32'h20, 32'd0, 4'h0, "b2bRd", waited, rd);
      checkOutput("b2b_accept_in_resp", waited, 32'd0);
      checkOutput("b2b_value", rd, 32'ha5a5_a5a5);

      // Random traffic, including back-to-back and out-of-range requests
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 60; i++) begin
            a = BASE + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) a = a ^ (32'd1 << $urandom_range(31, 14));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            applyStimulus(s, 1'($urandom_range(0, 1)), a, $urandom,
                          4'($urandom_range(0, 15)), "rand", waited, rd);
         end
      end

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
